// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/bubble/flush sequencing for the 5-stage pipeline,
// covering load-use, redirects, multi-cycle divide occupancy and memory wait states.
module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES  = 33,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd_addr,
    input  logic       ex_memRead,
    input  logic       ex_is_div,
    input  logic       ex_PCSel,
    input  logic       ex_trapReq,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       stall_mem,
    output logic       bubble_ex,
    output logic       bubble_mem,
    output logic       bubble_wb,
    output logic       flush_if_id,
    output logic       div_start,
    output logic       div_busy,
    output logic       mem_fault
);
    localparam int CW = DIV_CYCLES > 2 ? $clog2(DIV_CYCLES - 1) : 1;
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(DIV_CYCLES - 2);
    localparam logic [WW-1:0] W_MAX    = WW'(MEM_TIMEOUT);
    localparam logic [WW-1:0] W_FLT    = WW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DIV, DIV_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          fault_q, fault_d;
    logic          mstall, lu, redirect, start, div_run;

    assign mstall   = mem_req & ~mem_ready;
    assign redirect = ex_PCSel | ex_trapReq;
    assign lu       = ex_memRead & (ex_rd_addr != 5'd0) &
                      ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
                       (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));
    assign start    = (state_q == IDLE) & ~mstall & ~redirect & ex_is_div;
    assign div_run  = (state_q == DIV) & (cnt_q != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        stall_mem   = 1'b0;
        bubble_ex   = 1'b0;
        bubble_mem  = 1'b0;
        bubble_wb   = 1'b0;
        flush_if_id = 1'b0;
        div_start   = 1'b0;
        div_busy    = reset & (state_q != IDLE);
        mem_fault   = reset & mstall & (wait_q == W_FLT) & ~fault_q;
        fault_d     = mstall & (fault_q | mem_fault);
        wait_d      = mstall ? ((wait_q == W_MAX) ? wait_q : wait_q + WW'(1)) : '0;
        cnt_d       = start ? CNT_INIT : div_run ? cnt_q - CW'(1) : cnt_q;
        // A divide finishing under a memory stall parks in DIV_DONE until the release cycle
        state_d     = (state_q == IDLE) ? (start ? DIV : IDLE) :
                      div_run ? DIV : (mstall ? DIV_DONE : IDLE);
        if (reset) begin
            if (mstall) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                stall_mem = 1'b1;
                bubble_wb = 1'b1;
            end else if (redirect) begin
                flush_if_id = 1'b1;
                bubble_ex   = 1'b1;
            end else if (start || div_run) begin
                div_start  = start;
                stall_if   = 1'b1;
                stall_id   = 1'b1;
                stall_ex   = 1'b1;
                bubble_mem = 1'b1;
            end else if (state_q == IDLE && lu) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with a queued scoreboard; a negedge
// monitor pops one expected output vector per driven cycle.
module tb_pipe_hazard_ctrl;
    logic       clk, reset;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic       id_uses_rs1, id_uses_rs2, ex_memRead, ex_is_div, ex_PCSel, ex_trapReq;
    logic       mem_req, mem_ready;
    logic       stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem, bubble_wb;
    logic       flush_if_id, div_start, div_busy, mem_fault;
    logic [10:0] act;

    // Vector layout: {stall if,id,ex,mem}_{bubble ex,mem,wb}_{flush,div_start,div_busy,mem_fault}
    localparam logic [10:0] NONE   = 11'b0000_000_0000;
    localparam logic [10:0] LU     = 11'b1100_100_0000;
    localparam logic [10:0] DSTART = 11'b1110_010_0100;
    localparam logic [10:0] DSTALL = 11'b1110_010_0010;
    localparam logic [10:0] REL    = 11'b0000_000_0010;
    localparam logic [10:0] FLUSH  = 11'b0000_100_1000;
    localparam logic [10:0] MST    = 11'b1111_001_0000;
    localparam logic [10:0] MSTB   = 11'b1111_001_0010;
    localparam logic [10:0] MSTF   = 11'b1111_001_0001;
    localparam logic [10:0] MSTBF  = 11'b1111_001_0011;

    typedef struct {
        string       nm;
        logic [10:0] v;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    pipe_hazard_ctrl #(.DIV_CYCLES(4), .MEM_TIMEOUT(3)) dut (
        .clk(clk), .reset(reset),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd_addr(ex_rd_addr), .ex_memRead(ex_memRead), .ex_is_div(ex_is_div),
        .ex_PCSel(ex_PCSel), .ex_trapReq(ex_trapReq),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .bubble_wb(bubble_wb),
        .flush_if_id(flush_if_id), .div_start(div_start), .div_busy(div_busy),
        .mem_fault(mem_fault)
    );

    assign act = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem, bubble_wb,
                  flush_if_id, div_start, div_busy, mem_fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (act !== e.v) begin
                bad++;
                $display("FAIL %s: got %b want %b", e.nm, act, e.v);
            end
        end
    end

    task automatic chk(input string nm, input logic [10:0] v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_memRead = 0; ex_is_div = 0;
        ex_PCSel = 0; ex_trapReq = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic set_lu();
        ex_memRead = 1; ex_rd_addr = 5'd5; id_rs2_addr = 5'd5; id_uses_rs2 = 1;
    endtask

    initial begin
        reset = 0;
        clr();
        @(posedge clk);
        #1;
        ex_is_div = 1; mem_req = 1; ex_PCSel = 1; set_lu();
        chk("rst_gate", NONE);
        clr();
        reset = 1;
        chk("idle", NONE);

        set_lu();
        chk("lu_rs2", LU);
        ex_memRead = 0;
        chk("lu_after", NONE);
        clr(); ex_memRead = 1; ex_rd_addr = 5'd7; id_rs1_addr = 5'd7; id_uses_rs1 = 1;
        chk("lu_rs1", LU);
        clr(); ex_memRead = 1; id_uses_rs1 = 1; id_uses_rs2 = 1;
        chk("lu_x0", NONE);
        clr(); set_lu(); id_uses_rs2 = 0;
        chk("lu_unused", NONE);

        clr(); ex_is_div = 1;
        chk("div_c0", DSTART);
        chk("div_c1", DSTALL);
        chk("div_c2", DSTALL);
        chk("div_rel", REL);
        ex_is_div = 0;
        chk("div_done", NONE);

        set_lu(); ex_PCSel = 1;
        chk("br_over_lu", FLUSH);
        ex_PCSel = 0; ex_trapReq = 1;
        chk("trap_over_lu", FLUSH);

        clr(); ex_PCSel = 1; mem_req = 1;
        chk("br_mst0", MST);
        chk("br_mst1", MST);
        mem_ready = 1;
        chk("br_ready", FLUSH);
        clr();
        chk("br_after", NONE);

        ex_is_div = 1;
        chk("dm_c0", DSTART);
        chk("dm_c1", DSTALL);
        mem_req = 1;
        chk("dm_c2", MSTB);
        chk("dm_c3", MSTB);
        chk("dm_c4", MSTBF);
        chk("dm_c5", MSTB);
        mem_req = 0;
        chk("dm_rel", REL);
        ex_is_div = 0;
        chk("dm_idle", NONE);

        mem_req = 1;
        chk("to_1", MST);
        chk("to_2", MST);
        chk("to_3", MSTF);
        chk("to_4", MST);
        chk("to_5", MST);
        chk("to_6", MST);
        mem_ready = 1;
        chk("to_gap", NONE);
        mem_ready = 0;
        chk("to2_1", MST);
        chk("to2_2", MST);
        chk("to2_3", MSTF);
        clr();
        chk("to2_end", NONE);

        ex_is_div = 1;
        chk("rd_c0", DSTART);
        chk("rd_c1", DSTALL);
        reset = 0;
        chk("rd_rst", NONE);
        reset = 1;
        chk("rd_fresh", DSTART);
        chk("rd_c1b", DSTALL);
        chk("rd_c2b", DSTALL);
        chk("rd_rel", REL);
        ex_is_div = 0;
        chk("rd_idle", NONE);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
